// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch queue.
// The optional misaligned-fetch check is enabled with FETCH_MISALIGN_CHK_EN.
package fetch_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
        logic                fault;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous clear; head_data is the oldest entry.
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues PC fetches under a credit limit, pairs responses with PCs,
// buffers them for decode and flushes on redirect. Optional misaligned-PC fault: FETCH_MISALIGN_CHK_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_advance,
    input  logic            redirect_valid,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic            dec_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: a transfer happens on a clock edge where valid & ready are both high.
    // A raised imem_req_valid holds with a stable address until accepted, except that a
    // redirect may withdraw it. Responses are never backpressured. dec_* is show-ahead.

    fetch_state_t    state;
    fetch_state_t    state_nx;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   buf_count;
    logic [CW:0]     credit_used;
    logic            can_issue;
    logic            halted;
    logic            fault_push;
    logic            handshake;
    logic            rsp_take;
    logic            pcq_empty;
    logic [XLEN-1:0] pcq_head;
    logic            ibuf_empty;
    logic            ibuf_push;
    logic            ibuf_pop;
    fetch_entry_t    ibuf_in;
    fetch_entry_t    ibuf_head;
    logic            unused_pcq_full;
    logic [CW-1:0]   unused_pcq_count;
    logic            unused_ibuf_full;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = RUN;
            RUN:     if (redirect_valid) state_nx = FLUSH;
            FLUSH:   state_nx = redirect_valid ? FLUSH : RUN;
            default: state_nx = IDLE;
        endcase
    end

    assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
    assign can_issue   = (state == RUN) && !redirect_valid && !halted
                         && (credit_used < (CW+1)'(DEPTH));

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned     = (pc_in[1:0] != 2'b00);
    // A misaligned PC waits for in-flight fetches to drain, then emits one fault entry.
    assign fault_push     = can_issue && misaligned && (outstanding == '0);
    assign imem_req_valid = can_issue && !misaligned;
    assign dec_fault      = dec_valid && ibuf_head.fault;

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) halted <= 1'b0;
        else if (fault_push)         halted <= 1'b1;
    end
`else
    logic unused_fault;
    assign unused_fault   = ibuf_head.fault;
    assign halted         = 1'b0;
    assign fault_push     = 1'b0;
    assign imem_req_valid = can_issue;
    assign dec_fault      = 1'b0;
`endif

    assign imem_req_addr = pc_in;
    assign handshake     = imem_req_valid && imem_req_ready;
    assign pc_advance    = handshake;

    // A response in the redirect cycle is stale and folds into the discard count instead.
    assign rsp_take  = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign ibuf_push = rsp_take || fault_push;
    assign dec_valid = !ibuf_empty && !redirect_valid;
    assign ibuf_pop  = dec_valid && dec_ready;
    assign dec_instr = dec_valid ? ibuf_head.instr : '0;
    assign dec_pc    = dec_valid ? ibuf_head.pc : '0;

    always_comb begin
        ibuf_in = '0;
        if (fault_push) begin
            ibuf_in.pc    = pc_in;
            ibuf_in.instr = NOP_INSTR;
            ibuf_in.fault = 1'b1;
        end else begin
            ibuf_in.pc    = pcq_head;
            ibuf_in.instr = imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state <= state_nx;
            if (redirect_valid) begin
                outstanding <= '0;
                discard     <= discard + outstanding - CW'(imem_rsp_valid);
            end else begin
                outstanding <= outstanding + CW'(handshake) - CW'(rsp_take);
                if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(imem_rsp_valid && (discard == '0) && pcq_empty));
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (handshake),
        .push_data (pc_in),
        .pop       (rsp_take),
        .head_data (pcq_head),
        .empty     (pcq_empty),
        .full      (unused_pcq_full),
        .count     (unused_pcq_count)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (ibuf_push),
        .push_data (ibuf_in),
        .pop       (ibuf_pop),
        .head_data (ibuf_head),
        .empty     (ibuf_empty),
        .full      (unused_ibuf_full),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: PC register and in-order memory models, a table-driven stream check,
// directed multi-cycle corner cases, and a randomized run against a fetch-order reference model.
module tb_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        redirect_valid;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_fault;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .pc_advance     (pc_advance),
        .redirect_valid (redirect_valid),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_fault      (dec_fault)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } mem_t;

    mem_t        mem_q[$];      // requests the memory still owes a word for
    logic [31:0] exp_q[$];      // accepted fetches not yet consumed or flushed, in order
    int          n_arrived;     // leading exp_q entries whose word has been accepted
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          since_rst = 0;
    int          last_due = 0;
    int          lat = 1;
    int          hs_total = 0;
    bit          prev_redir = 0;
    bit          mon_en = 1;
    bit          rsp_is_live = 0;
    bit          pc_adv_s = 0;
    bit          want_first = 0;
    logic [31:0] first_pc;
    logic [31:0] redir_target;

    function automatic logic [31:0] word(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor (at negedge) ----------------
    task automatic monitor();
        bit running;
        bit exp_rv;
        bit exp_dv;
        running = (since_rst >= 1) && !prev_redir;
        exp_rv  = running && !redirect_valid && (exp_q.size() < DEPTH);
        exp_dv  = !redirect_valid && (n_arrived > 0);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("pc_advance", 32'(pc_advance), 32'(exp_rv && imem_req_ready));
        if (imem_req_valid) chk("req_addr", imem_req_addr, pc_in);
        chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
        chk("dec_fault", 32'(dec_fault), 32'(0));
        if (exp_dv && dec_ready) begin
            chk("dec_pc", dec_pc, exp_q[0]);
            chk("dec_instr", dec_instr, word(exp_q[0]));
            if (want_first) begin
                first_pc   = dec_pc;
                want_first = 0;
            end
            void'(exp_q.pop_front());
            n_arrived--;
        end
        if (imem_rsp_valid && rsp_is_live) n_arrived++;
        if (imem_req_valid && imem_req_ready) begin
            int due;
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: pc_in, due: due, live: 1'b1});
            exp_q.push_back(pc_in);
            hs_total++;
        end
        if (redirect_valid) begin
            exp_q.delete();
            n_arrived = 0;
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic advance();
        cyc++;
        since_rst++;
        prev_redir = redirect_valid;
        if (redirect_valid)  pc_in = redir_target;
        else if (pc_adv_s)   pc_in = pc_in + 32'd4;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        rsp_is_live    = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(mem_q[0].addr);
            rsp_is_live    = mem_q[0].live;
            void'(mem_q.pop_front());
        end
    endtask

    task automatic cycle_rest();
        pc_adv_s = pc_advance;
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic cycle();
        @(negedge clk);
        cycle_rest();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b0;
        dec_ready      = 1'b0;
        @(posedge clk);
        #1;
        mem_q.delete();
        exp_q.delete();
        n_arrived = 0;
        pc_in     = '0;
        last_due  = 0;
        cyc       = 0;
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'(0));
        chk("rst_pc_advance", 32'(pc_advance), 32'(0));
        chk("rst_req_addr", imem_req_addr, 32'(0));
        chk("rst_dec_valid", 32'(dec_valid), 32'(0));
        chk("rst_dec_instr", dec_instr, 32'(0));
        chk("rst_dec_pc", dec_pc, 32'(0));
        chk("rst_dec_fault", 32'(dec_fault), 32'(0));
        @(posedge clk);
        #1;
        reset      = 1'b0;
        since_rst  = 0;
        prev_redir = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        bit          rdy;
        bit          exp_rv;
        bit          exp_dv;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // Zero-wait stream: 2 credits against a 3-cycle issue/respond/consume loop.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h4};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h0,  32'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h4,  32'h8};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'hC};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h8,  32'h0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'hC,  32'h10};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h14};

        do_reset();
        imem_req_ready = 1'b1;
        lat = 1;
        for (int i = 0; i < 9; i++) begin
            dec_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_rv));
            chk($sformatf("tbl%0d_dec_valid", i), 32'(dec_valid), 32'(tbl[i].exp_dv));
            if (tbl[i].exp_rv) chk($sformatf("tbl%0d_addr", i), imem_req_addr, tbl[i].exp_addr);
            if (tbl[i].exp_dv) chk($sformatf("tbl%0d_dec_pc", i), dec_pc, tbl[i].exp_pc);
            cycle_rest();
        end

        // Backpressure: credits run out after two requests, then an in-order drain.
        do_reset();
        imem_req_ready = 1'b1;
        lat = 1;
        begin
            int h0;
            h0 = hs_total;
            for (int i = 0; i < 8; i++) cycle();
            chk("bp_issued", 32'(hs_total - h0), 32'd2);
            @(negedge clk);
            chk("bp_req_valid", 32'(imem_req_valid), 32'(0));
            chk("bp_pc_advance", 32'(pc_advance), 32'(0));
            cycle_rest();
            dec_ready  = 1'b1;
            want_first = 1'b1;
            first_pc   = 32'hDEAD_BEEF;
            for (int i = 0; i < 12; i++) cycle();
            chk("bp_first_pc", first_pc, 32'h0);
        end

        // Mid-stream reset with a full buffer, then restart from PC 0.
        dec_ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        @(negedge clk);
        chk("mrst_full_dec_valid", 32'(dec_valid), 32'(1));
        @(posedge clk);
        #1;
        do_reset();
        imem_req_ready = 1'b1;
        dec_ready  = 1'b1;
        want_first = 1'b1;
        first_pc   = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) cycle();
        chk("mrst_first_pc", first_pc, 32'h0);

        // Redirect with two fetches in flight at latency 3.
        do_reset();
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;
        lat = 3;
        for (int i = 0; i < 20 && pc_in != 32'h8; i++) cycle();
        chk("rd2_reached_pc8", pc_in, 32'h8);
        redirect_valid = 1'b1;
        redir_target   = 32'h100;
        want_first     = 1'b1;
        first_pc       = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) cycle();
        chk("rd2_first_pc", first_pc, 32'h100);

        // Redirect in the same cycle as a response with two outstanding.
        do_reset();
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;
        lat = 2;
        for (int i = 0; i < 20 && !(imem_rsp_valid && pc_in == 32'h8); i++) cycle();
        chk("rdsame_rsp_at_pc8", 32'(imem_rsp_valid && pc_in == 32'h8), 32'(1));
        redirect_valid = 1'b1;
        redir_target   = 32'h200;
        want_first     = 1'b1;
        first_pc       = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) cycle();
        chk("rdsame_first_pc", first_pc, 32'h200);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            dec_ready      = ($urandom_range(0, 2) != 0);
            lat            = $urandom_range(1, 4);
            if (since_rst >= 1 && mem_q.size() <= 3 && $urandom_range(0, 11) == 0) begin
                redirect_valid = 1'b1;
                redir_target   = 32'($urandom_range(0, 4095)) << 2;
            end
            cycle();
        end

`ifdef FETCH_MISALIGN_CHK_EN
        // Misaligned PC: one fault entry, then no requests until redirect.
        do_reset();
        mon_en = 1'b0;
        pc_in  = 32'h6;
        imem_req_ready = 1'b1;
        dec_ready = 1'b0;
        cycle();
        cycle();
        @(negedge clk);
        chk("mis_dec_valid", 32'(dec_valid), 32'(1));
        chk("mis_dec_fault", 32'(dec_fault), 32'(1));
        chk("mis_dec_instr", dec_instr, 32'h00000013);
        chk("mis_dec_pc", dec_pc, 32'h6);
        chk("mis_req_valid", 32'(imem_req_valid), 32'(0));
        cycle_rest();
        dec_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mis_halt_req_valid", 32'(imem_req_valid), 32'(0));
            chk("mis_halt_dec_valid", 32'(dec_valid), 32'(0));
            cycle_rest();
        end
        redirect_valid = 1'b1;
        redir_target   = 32'h40;
        cycle();
        cycle();
        @(negedge clk);
        chk("mis_resume_req_valid", 32'(imem_req_valid), 32'(1));
        chk("mis_resume_addr", imem_req_addr, 32'h40);
        cycle_rest();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
